// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle for the 4-way round-robin arbiter, plus read-only
// debug taps on the arbiter's state, round-robin pointer and hold counter.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       dbg_state;     // 0 = IDLE, 1 = GRANTED
  logic [1:0] dbg_last;
  logic [7:0] dbg_hold_cnt;

  // Requesters raise req[i] and keep it high while they need the mux path.
  // gnt[i] high means requester i owns the path. There is no per-beat
  // valid/ready: ownership lasts until req[i] drops, or until the hold limit
  // is reached while another requester is waiting.
  modport master (
    output req,
    input  gnt, sel, busy, dbg_state, dbg_last, dbg_hold_cnt
  );

  modport slave (
    input  req,
    output gnt, sel, busy, dbg_state, dbg_last, dbg_hold_cnt
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time. It drives a
// one-hot grant and a registered 4:1 mux select.
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter4_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

  state_t     state;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic [1:0] last;
  logic [7:0] hold_cnt;

  logic [3:0] owner_mask;
  logic [3:0] others;
  logic       release_now;
  logic [1:0] idle_pick;
  logic [1:0] next_pick;

  // First requester in the order base+1, base+2, base+3, base. Scanning from
  // farthest to nearest lets the nearest hit win without a loop break.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    pick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  // While GRANTED, sel always holds the owner index.
  always_comb begin
    owner_mask  = 4'b0001 << sel;
    others      = bus.req & ~owner_mask;
    release_now = ~(|(bus.req & owner_mask)) ||
                  ((hold_cnt == HOLD_LIM) && (|others));
    idle_pick   = pick(bus.req, last);
    next_pick   = pick(others, sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'b00;
      busy     <= 1'b0;
      last     <= 2'b11;
      hold_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= GRANTED;
            gnt      <= 4'b0001 << idle_pick;
            sel      <= idle_pick;
            busy     <= 1'b1;
            last     <= idle_pick;
            hold_cnt <= 8'd0;
          end
        end
        GRANTED: begin
          if (release_now) begin
            if (|others) begin
              // Hand over on the same edge so the path never idles.
              gnt      <= 4'b0001 << next_pick;
              sel      <= next_pick;
              last     <= next_pick;
              hold_cnt <= 8'd0;
            end else begin
              state    <= IDLE;
              gnt      <= 4'b0000;
              busy     <= 1'b0;
              hold_cnt <= 8'd0;
            end
          end else if (hold_cnt != HOLD_LIM) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt          = gnt;
  assign bus.sel          = sel;
  assign bus.busy         = busy;
  assign bus.dbg_state    = state;
  assign bus.dbg_last     = last;
  assign bus.dbg_hold_cnt = hold_cnt;

endmodule
